// File: rtl/grid_walker.sv
// grid_walker: (x,y) cursor on a bounded grid, moved one command per
// rising edge of the rotary event, with a circular undo history.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   evt         rotary event level; a rising edge starts one command
//   cmd         [1:0] dir (N,E,S,W), [W+1:2] step magnitude
//   undo        revert the newest history entry instead of moving
//   x, y        current position (registered)
//   clip        one-cycle pulse: forward move clamped or wrapped
//   err         one-cycle pulse: undo with empty history
//   busy        high while the command executes
//   hist_cnt    number of valid history entries
module grid_walker #(
   parameter int W     = 4,
   parameter int XMAX  = 2**W-1,
   parameter int YMAX  = 2**W-1,
   parameter int WRAP  = 0,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       evt,
   input  logic [W+1:0]               cmd,
   input  logic                       undo,
   output logic [W-1:0]               x,
   output logic [W-1:0]               y,
   output logic                       clip,
   output logic                       err,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [W:0]    XM      = (W+1)'(XMAX);
   localparam logic [W:0]    YM      = (W+1)'(YMAX);
   localparam logic [W:0]    XMOD    = (W+1)'(XMAX + 1);
   localparam logic [W:0]    YMOD    = (W+1)'(YMAX + 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
   localparam bit            WRAP_EN = (WRAP != 0);

   typedef enum logic {
      IDLE,
      EXEC
   } state_t;

   state_t state;
   state_t state_nx;

   logic          prev_evt;
   logic          evt_rise;
   logic [W+1:0]  num;
   logic          undo_q;

   // History entry: [1:0] dir of the move, [W+1:2] applied displacement
   logic [W+1:0]  hist [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_nx;
   logic [CW-1:0] cnt;
   logic [W+1:0]  rd_entry;

   logic [1:0]    mv_dir;
   logic [W-1:0]  mv_mag;
   logic          mv_x;
   logic          mv_up;
   logic [W:0]    coord;
   logic [W:0]    lim;
   logic [W:0]    modv;
   logic [W:0]    red;
   logic [W:0]    red_x;
   logic [W:0]    red_y;
   logic [W:0]    sum;
   logic [W:0]    dif;
   logic [W:0]    res;
   logic          mv_clip;
   logic [W-1:0]  mv_disp;

   logic          do_move;
   logic          do_push;
   logic          do_pop;
   logic          err_nx;

   assign evt_rise = evt & ~prev_evt;
   assign busy     = (state == EXEC);
   assign hist_cnt = cnt;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (evt_rise) state_nx = EXEC;
         EXEC:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- history pointers ----------------
   assign rd_ptr   = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
   assign wr_nx    = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
   assign rd_entry = hist[rd_ptr];

   // ---------------- move arithmetic ----------------
   // Undo replays the stored entry with the direction reversed
   // (flipping dir[1] swaps N<->S and E<->W).
   assign mv_dir = undo_q ? (rd_entry[1:0] ^ 2'b10) : num[1:0];
   assign mv_mag = undo_q ? rd_entry[W+1:2] : num[W+1:2];
   assign mv_x   = mv_dir[0];
   assign mv_up  = ~mv_dir[1];

   assign red_x  = {1'b0, mv_mag} % XMOD;
   assign red_y  = {1'b0, mv_mag} % YMOD;

   always_comb begin
      coord   = {1'b0, (mv_x ? x : y)};
      lim     = mv_x ? XM : YM;
      modv    = mv_x ? XMOD : YMOD;
      red     = WRAP_EN ? (mv_x ? red_x : red_y) : {1'b0, mv_mag};
      sum     = coord + red;
      dif     = coord - red;
      res     = coord;
      mv_clip = 1'b0;
      if (mv_up) begin
         if (sum > lim) begin
            mv_clip = 1'b1;
            res     = WRAP_EN ? sum - modv : lim;
         end else begin
            res     = sum;
         end
      end else begin
         // red > coord is the borrow of the W+1 bit difference
         if (red > coord) begin
            mv_clip = 1'b1;
            res     = WRAP_EN ? dif + modv : '0;
         end else begin
            res     = dif;
         end
      end
      if (WRAP_EN)    mv_disp = red[W-1:0];
      else if (mv_up) mv_disp = res[W-1:0] - coord[W-1:0];
      else            mv_disp = coord[W-1:0] - res[W-1:0];
   end

   // ---------------- EXEC decisions ----------------
   always_comb begin
      do_move = 1'b0;
      do_push = 1'b0;
      do_pop  = 1'b0;
      err_nx  = 1'b0;
      if (state == EXEC) begin
         if (undo_q) begin
            if (cnt == '0) begin
               err_nx = 1'b1;
            end else begin
               do_move = 1'b1;
               do_pop  = 1'b1;
            end
         end else if (num[W+1:2] != '0) begin
            do_move = 1'b1;
            do_push = 1'b1;
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_evt <= 1'b1;
         num      <= '0;
         undo_q   <= 1'b0;
         x        <= '0;
         y        <= '0;
         clip     <= 1'b0;
         err      <= 1'b0;
         cnt      <= '0;
         wr_ptr   <= '0;
      end else begin
         prev_evt <= evt;
         clip     <= do_push & mv_clip;
         err      <= err_nx;
         if (state == IDLE && evt_rise) begin
            num    <= cmd;
            undo_q <= undo;
         end
         if (do_move) begin
            if (mv_x) x <= res[W-1:0];
            else      y <= res[W-1:0];
         end
         if (do_push) begin
            wr_ptr <= wr_nx;
            if (cnt != FULL) cnt <= cnt + 1'b1;
         end else if (do_pop) begin
            wr_ptr <= rd_ptr;
            cnt    <= cnt - 1'b1;
         end
      end
   end

   // History storage needs no reset; hist_cnt qualifies its contents.
   always_ff @(posedge clk) begin
      if (rst_n && do_push) hist[wr_ptr] <= {mv_disp, mv_dir};
   end

endmodule

// File: tb/tb_grid_walker.sv
// tb_grid_walker: two grid_walker instances (saturating 16x16 depth 8,
// wrapping 10x13 depth 4) checked every cycle against a behavioural model.
module tb_grid_walker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       evt;
   logic       undo;
   logic [5:0] cmd;

   logic [3:0] x0, y0, hc0;
   logic       clip0, err0, busy0;
   logic [3:0] x1, y1;
   logic [2:0] hc1;
   logic       clip1, err1, busy1;

   always #5 clk = ~clk;

   grid_walker #(.W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .evt(evt), .cmd(cmd), .undo(undo),
      .x(x0), .y(y0), .clip(clip0), .err(err0), .busy(busy0),
      .hist_cnt(hc0)
   );

   grid_walker #(.W(4), .XMAX(9), .YMAX(12), .WRAP(1), .DEPTH(4)) u1 (
      .clk(clk), .rst_n(rst_n), .evt(evt), .cmd(cmd), .undo(undo),
      .x(x1), .y(y1), .clip(clip1), .err(err1), .busy(busy1),
      .hist_cnt(hc1)
   );

   int nerr = 0;
   int nchk = 0;
   bit armed = 1'b0;

   task automatic chk(string name, int act, int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int XM[2] = '{15, 9};
   int YM[2] = '{15, 12};
   int WR[2] = '{0, 1};
   int DP[2] = '{8, 4};

   int ex[2], ey[2], eclip[2], eerr[2], ebusy;
   int hdir[2][8];
   int hmag[2][8];
   int hn[2];

   bit         m_prev;
   bit         m_pend;
   bit         m_undo;
   logic [5:0] m_cmd;

   task automatic m_move(int k, int dir, int mag, bit is_undo);
      int m, c, t, n, d;
      bit isx, up, cl;
      isx = (dir == 1 || dir == 3);
      up  = (dir == 0 || dir == 1);
      m   = isx ? XM[k] : YM[k];
      c   = isx ? ex[k] : ey[k];
      if (WR[k] != 0) begin
         d  = mag % (m + 1);
         t  = up ? c + d : c - d;
         n  = ((t % (m + 1)) + (m + 1)) % (m + 1);
         cl = (t < 0) || (t > m);
      end else begin
         t  = up ? c + mag : c - mag;
         n  = (t < 0) ? 0 : ((t > m) ? m : t);
         d  = (n > c) ? n - c : c - n;
         cl = (t != n);
      end
      if (isx) ex[k] = n;
      else     ey[k] = n;
      if (!is_undo) begin
         eclip[k] = cl ? 1 : 0;
         if (hn[k] == DP[k]) begin
            for (int i = 0; i < 7; i++) begin
               hdir[k][i] = hdir[k][i+1];
               hmag[k][i] = hmag[k][i+1];
            end
            hn[k]--;
         end
         hdir[k][hn[k]] = dir;
         hmag[k][hn[k]] = d;
         hn[k]++;
      end
   endtask

   task automatic m_exec(int k);
      int step, dir;
      step = int'(m_cmd[5:2]);
      dir  = int'(m_cmd[1:0]);
      if (m_undo) begin
         if (hn[k] == 0) begin
            eerr[k] = 1;
         end else begin
            hn[k]--;
            m_move(k, hdir[k][hn[k]] ^ 2, hmag[k][hn[k]], 1'b1);
         end
      end else if (step != 0) begin
         m_move(k, dir, step, 1'b0);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         armed = 1'b1;
         for (int k = 0; k < 2; k++) begin
            eclip[k] = 0;
            eerr[k]  = 0;
         end
         if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
               ex[k] = 0;
               ey[k] = 0;
               hn[k] = 0;
            end
            m_prev = 1'b1;
            m_pend = 1'b0;
         end else begin
            if (m_pend) begin
               m_exec(0);
               m_exec(1);
               m_pend = 1'b0;
            end else if (evt && !m_prev) begin
               m_cmd  = cmd;
               m_undo = undo;
               m_pend = 1'b1;
            end
            m_prev = evt;
         end
         ebusy = m_pend ? 1 : 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            chk("x0", int'(x0), ex[0]);
            chk("y0", int'(y0), ey[0]);
            chk("clip0", int'(clip0), eclip[0]);
            chk("err0", int'(err0), eerr[0]);
            chk("busy0", int'(busy0), ebusy);
            chk("hist_cnt0", int'(hc0), hn[0]);
            chk("x1", int'(x1), ex[1]);
            chk("y1", int'(y1), ey[1]);
            chk("clip1", int'(clip1), eclip[1]);
            chk("err1", int'(err1), eerr[1]);
            chk("busy1", int'(busy1), ebusy);
            chk("hist_cnt1", int'(hc1), hn[1]);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic cap_clip0, cap_clip1, cap_err0, cap_err1;

   task automatic send(int dir, int step, bit u);
      logic [3:0] s;
      logic [1:0] d;
      s = step[3:0];
      d = dir[1:0];
      @(posedge clk); #1;
      evt  = 1'b1;
      cmd  = {s, d};
      undo = u;
      @(posedge clk); #1;
      evt = 1'b0;
      @(posedge clk); #1;
      cap_clip0 = clip0;
      cap_clip1 = clip1;
      cap_err0  = err0;
      cap_err1  = err1;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   localparam int N = 0, E = 1, S = 2, WD = 3;

   initial begin
      rst_n = 1'b0;
      evt   = 1'b1;
      undo  = 1'b0;
      cmd   = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      // evt held high through reset release: no move
      repeat (4) @(posedge clk);
      #1;
      chk("lit_reset_x0", int'(x0), 0);
      chk("lit_reset_busy0", int'(busy0), 0);
      chk("lit_reset_cnt0", int'(hc0), 0);
      evt = 1'b0;

      // saturate east
      for (int i = 1; i <= 5; i++) begin
         send(E, 3, 1'b0);
         chk("lit_east_x0", int'(x0), 3 * i);
      end
      send(E, 3, 1'b0);
      chk("lit_sat_x0", int'(x0), 15);
      chk("lit_sat_clip0", int'(cap_clip0), 1);
      chk("lit_sat_cnt0", int'(hc0), 6);
      chk("lit_wrap_x1", int'(x1), 8);
      chk("lit_wrap_cnt1", int'(hc1), 4);

      // south underflow and undo
      send(N, 2, 1'b0);
      send(S, 5, 1'b0);
      chk("lit_south_y0", int'(y0), 0);
      chk("lit_south_clip0", int'(cap_clip0), 1);
      chk("lit_south_y1", int'(y1), 10);
      send(N, 0, 1'b1);
      chk("lit_undo_y0", int'(y0), 2);
      chk("lit_undo_clip0", int'(cap_clip0), 0);
      chk("lit_undo_y1", int'(y1), 2);
      chk("lit_undo_clip1", int'(cap_clip1), 0);

      // wrap mode on instance 1
      send(E, 4, 1'b0);
      chk("lit_wrapE_x1", int'(x1), 2);
      chk("lit_wrapE_clip1", int'(cap_clip1), 1);
      send(WD, 13, 1'b0);
      chk("lit_wrapW_x1", int'(x1), 9);

      // history overflow
      do_reset();
      for (int i = 1; i <= 5; i++) send(N, i, 1'b0);
      chk("lit_ovf_y0", int'(y0), 15);
      chk("lit_ovf_cnt1", int'(hc1), 4);
      for (int i = 0; i < 4; i++) send(N, 0, 1'b1);
      chk("lit_ovf_undo_y1", int'(y1), 1);
      send(N, 0, 1'b1);
      chk("lit_ovf_err1", int'(cap_err1), 1);
      chk("lit_ovf_y1", int'(y1), 1);
      chk("lit_ovf_cnt1_0", int'(hc1), 0);
      chk("lit_ovf_y0_0", int'(y0), 0);
      chk("lit_ovf_err0", int'(cap_err0), 0);

      // edge timing and long evt hold
      @(posedge clk); #1;
      evt = 1'b1;
      cmd = {4'd1, 2'd0};
      undo = 1'b0;
      @(posedge clk); #1;
      chk("lit_t1_busy0", int'(busy0), 1);
      chk("lit_t1_y0", int'(y0), 0);
      @(posedge clk); #1;
      chk("lit_t2_busy0", int'(busy0), 0);
      chk("lit_t2_y0", int'(y0), 1);
      repeat (8) @(posedge clk);
      #1 evt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("lit_hold_cnt0", int'(hc0), 1);
      chk("lit_hold_y0", int'(y0), 1);

      // reset during EXEC
      @(posedge clk); #1;
      evt = 1'b1;
      cmd = {4'd2, 2'd1};
      @(posedge clk); #1;
      evt = 1'b0;
      chk("lit_mid_busy0", int'(busy0), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("lit_mid_x0", int'(x0), 0);
      chk("lit_mid_y0", int'(y0), 0);
      chk("lit_mid_cnt0", int'(hc0), 0);
      @(posedge clk); #1;
      chk("lit_mid_clip0", int'(clip0), 0);
      chk("lit_mid_err0", int'(err0), 0);
      chk("lit_mid_x0b", int'(x0), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         evt   = ($urandom_range(0, 2) == 0);
         cmd   = 6'($urandom_range(0, 63));
         undo  = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 399) != 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      evt   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
